// File: rtl/rv32_pkg.sv
// Shared RV32I control definitions: ALU operation codes, opcodes, FSM states,
// datapath mux encodings and the instruction support check used by DECODE.
package rv32_pkg;

   // ALU operation codes, shared with the ALU itself
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLT = 3'd5;
   localparam logic [2:0] ALU_SL  = 3'd6;
   localparam logic [2:0] ALU_SR  = 3'd7;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      SRC_A_RS1  = 2'd0,
      SRC_A_PC   = 2'd1,
      SRC_A_ZERO = 2'd2
   } src_a_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_ALU   = 2'd2
   } pc_sel_t;

   // Instruction class as seen by the ALU decoder; everything else is a plain add
   typedef enum logic [1:0] {
      CLS_ADDR   = 2'd0,
      CLS_OP     = 2'd1,
      CLS_OP_IMM = 2'd2,
      CLS_BRANCH = 2'd3
   } alu_class_t;

   // SLTU/SLTIU/BLTU/BGEU, the reserved branch encodings, FENCE and SYSTEM all trap
   function automatic logic is_supported(input logic [6:0] opc, input logic [2:0] f3);
      logic ok;
      case (opc)
         OPC_OP, OPC_OP_IMM: ok = (f3 != 3'b011);
         OPC_BRANCH:         ok = (f3 == 3'b000) || (f3 == 3'b001) ||
                                  (f3 == 3'b100) || (f3 == 3'b101);
         OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: ok = 1'b1;
         default:            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from instruction class, funct3 and funct7[5] to the ALU
// operation code and the arithmetic-shift flag.
module alu_decoder
   import rv32_pkg::*;
(
   input  logic [1:0] cls,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [2:0] alu_ctrl,
   output logic       arith
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      arith    = 1'b0;
      case (cls)
         CLS_OP, CLS_OP_IMM: begin
            case (funct3)
               // only register-register ops use funct7[5] to pick SUB; ADDI never does
               3'b000:  alu_ctrl = ((cls == CLS_OP) && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101: begin
                  alu_ctrl = ALU_SR;
                  arith    = funct7_5;
               end
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         // BEQ/BNE compare through SUB's zero flag, BLT/BGE through SLT's LSB
         CLS_BRANCH: alu_ctrl = funct3[2] ? ALU_SLT : ALU_SUB;
         default: begin
            alu_ctrl = ALU_ADD;
            arith    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a
// shared memory port, with a sticky TRAP state for unsupported instructions.
module multicycle_ctrl
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       alu_lsb,
   input  logic       mem_ready,
   output logic [2:0] alu_ctrl,
   output logic       arith,
   output logic [1:0] alu_src_a,
   output logic       alu_src_b,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       pc_rst,
   output logic       retired,
   output logic       illegal
);

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] alu_cls;
   logic [2:0] dec_alu_ctrl;
   logic       dec_arith;
   logic       branch_taken;
   logic       is_store;
   logic [31:0] unused_reset_pc;

   // The datapath takes its reset vector from this parameter; nothing here consumes it
   assign unused_reset_pc = RESET_PC;

   always_comb begin
      alu_cls = CLS_ADDR;
      case (opcode)
         OPC_OP:     alu_cls = CLS_OP;
         OPC_OP_IMM: alu_cls = CLS_OP_IMM;
         OPC_BRANCH: alu_cls = CLS_BRANCH;
         default:    alu_cls = CLS_ADDR;
      endcase
   end

   alu_decoder u_alu_decoder (
      .cls      (alu_cls),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_ctrl (dec_alu_ctrl),
      .arith    (dec_arith)
   );

   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:  branch_taken = zero;
         3'b001:  branch_taken = !zero;
         3'b100:  branch_taken = alu_lsb;
         3'b101:  branch_taken = !alu_lsb;
         default: branch_taken = 1'b0;
      endcase
   end

   assign is_store = (opcode == OPC_STORE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // All strobes sit inside the !rst branch so a reset cycle can never write anything
   always_comb begin
      state_next = state_reg;
      alu_ctrl   = ALU_ADD;
      arith      = 1'b0;
      alu_src_a  = SRC_A_RS1;
      alu_src_b  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = WB_ALU;
      pc_we      = 1'b0;
      pc_sel     = PC_PLUS4;
      if (!rst) begin
         case (state_reg)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we      = 1'b1;
                  state_next = ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (is_supported(opcode, funct3)) begin
                  state_next = ST_EXEC;
               end else begin
                  state_next = ST_TRAP;
               end
            end
            ST_EXEC: begin
               alu_ctrl = dec_alu_ctrl;
               arith    = dec_arith;
               case (opcode)
                  OPC_OP: state_next = ST_WB;
                  OPC_OP_IMM, OPC_JALR: begin
                     alu_src_b  = 1'b1;
                     state_next = ST_WB;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     alu_src_b  = 1'b1;
                     state_next = ST_MEM;
                  end
                  OPC_LUI: begin
                     alu_src_a  = SRC_A_ZERO;
                     alu_src_b  = 1'b1;
                     state_next = ST_WB;
                  end
                  OPC_AUIPC: begin
                     alu_src_a  = SRC_A_PC;
                     alu_src_b  = 1'b1;
                     state_next = ST_WB;
                  end
                  OPC_JAL: state_next = ST_WB;
                  OPC_BRANCH: begin
                     pc_we      = 1'b1;
                     pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
                     state_next = ST_FETCH;
                  end
                  default: state_next = ST_TRAP;
               endcase
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = is_store;
               if (mem_ready) begin
                  if (is_store) begin
                     pc_we      = 1'b1;
                     state_next = ST_FETCH;
                  end else begin
                     state_next = ST_WB;
                  end
               end
            end
            ST_WB: begin
               reg_we     = 1'b1;
               pc_we      = 1'b1;
               state_next = ST_FETCH;
               case (opcode)
                  OPC_LOAD: wb_sel = WB_MEM;
                  OPC_JAL: begin
                     wb_sel = WB_PC4;
                     pc_sel = PC_IMM;
                  end
                  OPC_JALR: begin
                     wb_sel = WB_PC4;
                     pc_sel = PC_ALU;
                  end
                  default: wb_sel = WB_ALU;
               endcase
            end
            ST_TRAP:  state_next = ST_TRAP;
            default:  state_next = ST_FETCH;
         endcase
      end
   end

   // Every instruction completes in exactly the cycle its PC update is written
   assign retired = pc_we;
   assign illegal = !rst && (state_reg == ST_TRAP);
   assign pc_rst  = rst;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core. It drives the ALU's `alu_ctrl`/`arith` inputs and consumes the ALU's `zero` and result LSB, sequencing fetch, decode, execute, memory and writeback over a shared instruction/data memory port. The datapath (PC, IR, register file, ALU result register, PC adders) is separate and follows this block's strobes.

## Interface
- `RESET_PC`: default `32'h0000_0000`. PC value the datapath loads while `pc_rst` is high; this block only forwards it.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high.
- `opcode` in 7: `IR[6:0]`.
- `funct3` in 3: `IR[14:12]`.
- `funct7_5` in 1: `IR[30]`.
- `zero` in 1: ALU zero flag.
- `alu_lsb` in 1: ALU `alu_out[0]`.
- `mem_ready` in 1: memory accepts the write or returns read data this cycle.
- `alu_ctrl` out 3: ALU operation code.
- `arith` out 1: arithmetic right shift.
- `alu_src_a` out 2: 0 = RS1, 1 = PC, 2 = ZERO.
- `alu_src_b` out 1: 0 = RS2, 1 = IMM.
- `mem_req` out 1: memory request.
- `mem_we` out 1: store.
- `addr_sel` out 1: 0 = PC, 1 = ALU result register.
- `ir_we` out 1: latch IR and old PC.
- `reg_we` out 1: register file write enable.
- `wb_sel` out 2: 0 = ALU result, 1 = memory data, 2 = PC+4.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 2: 0 = PC+4, 1 = PC+IMM, 2 = ALU result & ~1.
- `pc_rst` out 1: equals `rst`.
- `retired` out 1: one-cycle pulse per completed instruction.
- `illegal` out 1: sticky trap flag.

## Operation
States and transitions:
- FETCH: `mem_req=1`, `addr_sel=0`. Holds until `mem_ready`. On `mem_ready`, asserts `ir_we` and goes to DECODE.
- DECODE: no strobes. Goes to TRAP if the instruction is unsupported, otherwise to EXEC.
  - Unsupported: SLTU, SLTIU, BLTU, BGEU, FENCE, ECALL, EBREAK, any unknown opcode.
- EXEC: ALU setup per instruction class.
  - OP: `alu_src_a=0`, `alu_src_b=0`. `funct3` 000 with `funct7_5=1` selects SUB, 000 otherwise ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SL, 101 SR. Next: WB.
  - OP-IMM: same mapping with `alu_src_b=1`. `funct7_5` matters only for 101 (shift right), where it selects SRAI. ADDI never selects SUB. Next: WB.
  - `arith = funct7_5` only when the operation is SR; otherwise `arith=0`.
  - LOAD/STORE: ADD, RS1+IMM. Next: MEM.
  - LUI: ADD, ZERO+IMM. Next: WB.
  - AUIPC: ADD, PC+IMM. Next: WB.
  - JAL: no ALU use. Next: WB.
  - JALR: ADD, RS1+IMM. Next: WB.
  - BRANCH: BEQ/BNE use SUB, BLT/BGE use SLT, both on RS1, RS2.
    - Taken: BEQ when `zero`, BNE when `!zero`, BLT when `alu_lsb`, BGE when `!alu_lsb`.
    - Same cycle: `pc_we=1`, `pc_sel` = 1 if taken else 0, `retired=1`. Next: FETCH.
- MEM: `mem_req=1`, `addr_sel=1`, `mem_we` set for stores. Access size comes from `funct3` in the datapath. Holds until `mem_ready`.
  - Load: go to WB.
  - Store: `pc_we=1`, `pc_sel=0`, `retired=1`, go to FETCH.
- WB: `reg_we=1`, `pc_we=1`, `retired=1`, go to FETCH.
  - `wb_sel`: 1 for loads, 2 for JAL/JALR, 0 otherwise.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 otherwise.
- TRAP: `illegal=1` and all strobes 0. Stays in TRAP until `rst`.
- When not driven by the rules above: all strobes are 0, `alu_ctrl` = ADD, `arith` = 0.

## Timing
- Reset:
  - While `rst` is high, every output is 0 except `pc_rst` (and `alu_ctrl`, which is ADD = 0).
  - Strobes are gated by `rst` combinationally, so no write happens in any reset cycle.
  - State returns to FETCH and `illegal` clears.
  - The first `mem_req` appears in the cycle after `rst` falls.
- Reset mid-operation:
  - The instruction is aborted with no `reg_we` or `pc_we`.
  - Any pending memory request is dropped. The memory must tolerate `mem_req` falling without `mem_ready`.
- Handshake:
  - `mem_req`, `mem_we` and `addr_sel` stay stable until the cycle in which `mem_ready=1`.
  - `mem_ready` is ignored when `mem_req=0`.
  - Same-cycle ready (zero wait) is legal.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- `retired` is high in exactly one cycle per instruction, the same cycle as that instruction's `pc_we`.

## Structure
- Shared package `rv32_pkg`:
  - ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SL=6, SR=7. These are shared with the ALU.
  - Opcode constants.
  - State enum.
  - Enums for `alu_src_a`, `wb_sel` and `pc_sel`.
- One sub-module, `alu_decoder`: combinational mapping of (class, `funct3`, `funct7_5`) to (`alu_ctrl`, `arith`). The FSM stays in `multicycle_ctrl`.

## Test plan
- Reset and zero-wait ADD:
  - Hold `rst` for 2 cycles, then feed ADD x3,x1,x2 (`opcode`=0110011, `funct3`=0, `funct7_5`=0).
  - Required: outputs 0 during reset; `ir_we` in cycle 1; EXEC shows `alu_ctrl=0`, `src_a=0`, `src_b=0`; WB shows `reg_we`, `pc_we`, `pc_sel=0`, `retired`.
- Shifts:
  - SRAI (`funct3`=101, `funct7_5`=1) gives `alu_ctrl=7`, `arith=1`.
  - SRLI gives `arith=0`.
  - ADDI with `funct7_5=1` gives `alu_ctrl=0`.
- Branches:
  - BEQ with `zero=1` gives `pc_we`, `pc_sel=1` in the 3rd cycle.
  - BGE with `alu_lsb=1` gives `pc_sel=0`.
- Load with waits:
  - LW with `mem_ready` delayed 2 cycles in MEM.
  - Required: `mem_req`/`addr_sel=1` held 3 cycles, then WB with `wb_sel=1`; total 7 cycles.
- Trap:
  - SLTU (`opcode`=0110011, `funct3`=011).
  - Required: `illegal=1` from the cycle after DECODE, no further `mem_req`, cleared only by `rst`.
- Reset mid-access:
  - Assert `rst` during a store wait.
  - Required: no `pc_we`/`reg_we`; FETCH with `mem_req=1` the cycle after release.
